mem_bridge: RTL and testbench
=============================

# mem_bridge

Memory-side bridge between the LC-3b multicycle core's memory port and the physical memory bus. The control FSM holds `mem_read`/`mem_write` level-high and waits for `mem_resp`. This block turns each held request into exactly one granted/acknowledged bus transaction and returns a single-cycle `mem_resp` with registered read data. A timeout watchdog guarantees the core never hangs on a dead bus.

## Interface
- `TIMEOUT`, default 255: max cycles spent in REQ+WAIT before forcing an error response; legal range 1..255.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_address` in 16: CPU byte address (`lc3b_word`).
- `mem_wdata` in 16: CPU write data.
- `mem_read` in 1: CPU read request, level-held until `mem_resp`.
- `mem_write` in 1: CPU write request, level-held until `mem_resp`.
- `mem_byte_enable` in 2: write lane mask (`lc3b_mem_wmask`); bit0 = low byte.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 16: registered read data, stable between captures.
- `mem_err` out 1: high during `mem_resp` when the transaction timed out.
- `pmem_req` out 1: bus request, held until `pmem_gnt`.
- `pmem_we` out 1: 1 = write.
- `pmem_addr` out 16: latched address, with bit0 forced to 0 (word aligned).
- `pmem_wdata` out 16: latched write data.
- `pmem_wmask` out 2: latched lane mask on writes, 2'b11 on reads.
- `pmem_gnt` in 1: bus accepted the request.
- `pmem_ack` in 1: bus completion; carries read data for reads.
- `pmem_rdata` in 16: read data, valid when `pmem_ack`=1.

## Operation
- States:
  - IDLE: no transaction active.
  - REQ: `pmem_req`=1, waiting for grant.
  - WAIT: waiting for `pmem_ack`.
  - RESP: `mem_resp`=1 for exactly one cycle.
- IDLE:
  - If `mem_read` or `mem_write` is high, latch `mem_address`, `mem_wdata`, `mem_byte_enable`, and direction; clear the timeout counter; go to REQ.
  - If both are high, write wins.
- REQ:
  - `pmem_gnt`=1 and `pmem_ack`=1 → RESP.
  - `pmem_gnt`=1 only → WAIT.
  - Otherwise stay in REQ.
- WAIT: `pmem_ack`=1 → RESP.
- Read completion: on `pmem_ack`, capture `pmem_rdata` into `mem_rdata`. Writes leave `mem_rdata` unchanged.
- Timeout:
  - An 8-bit counter increments every cycle in REQ or WAIT.
  - When count = `TIMEOUT` and `pmem_ack`=0, go to RESP with `mem_err`=1, `mem_rdata`=16'h0000, and drop `pmem_req`.
  - Ack in the same cycle as timeout: the ack wins and `mem_err`=0.
- RESP → IDLE unconditionally. A CPU request still asserted during the RESP cycle is not re-sampled, so each held request produces one bus transaction.
- CPU input changes after latching are ignored until the next IDLE.
- `pmem_ack` or `pmem_gnt` arriving while in IDLE (stray or post-reset) is ignored.
- Reset (async, any time): state=IDLE, counter=0, all latches=0.
  - Reset values: `mem_resp`=0, `mem_err`=0, `mem_rdata`=0, `pmem_req`=0, `pmem_we`=0, `pmem_addr`=0, `pmem_wdata`=0, `pmem_wmask`=2'b00.
  - Any in-flight transaction is abandoned.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from CPU inputs to `pmem_*`.
- Request seen at edge N (IDLE) → `pmem_req` high from cycle N+1.
- Minimum latency: request at cycle 0, grant+ack at cycle 1 → `mem_resp` at cycle 2.
- Typical latency: grant at cycle 1, ack at cycle 2 → `mem_resp` at cycle 3.
- `mem_rdata` is valid in the `mem_resp` cycle and holds thereafter.
- Earliest next transaction: the cycle after RESP returns to IDLE, so back-to-back transactions are spaced at least 1 idle cycle apart.

## Structure
- `lc3b_types` already supplies `lc3b_word` and `lc3b_mem_wmask`. Add `lc3b_membr_state` (IDLE/REQ/WAIT/RESP) and `MEMBR_TIMEOUT_W = 8` there.
- One natural sub-module: `mem_timeout_ctr` (clear, enable, terminal-count compare against `TIMEOUT`).
- Remainder is the FSM plus latch registers; roughly 150–250 lines.

## Test plan
- Read, grant cycle 1, ack cycle 3 with `pmem_rdata`=16'hBEEF → single `mem_resp` at cycle 4, `mem_rdata`=16'hBEEF, `mem_err`=0, `pmem_wmask`=2'b11.
- Write `mem_address`=16'h3001, byte_enable=2'b10, wdata=16'h5A00 → `pmem_addr`=16'h3000, `pmem_wmask`=2'b10, `pmem_we`=1; exactly one `pmem_req` grant even though `mem_write` stays high through RESP.
- `TIMEOUT`=4, no ack → `mem_resp` with `mem_err`=1 and `mem_rdata`=0 five cycles after the request; ack and timeout in the same cycle → `mem_err`=0.
- `mem_read`=`mem_write`=1 → write transaction issued (`pmem_we`=1).
- Assert `rst_n`=0 in WAIT → outputs zero immediately; a later stray `pmem_ack` produces no `mem_resp`.
- Change `mem_address` mid-transaction → `pmem_addr` keeps the latched value.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// Shared types for the LC-3b memory bridge: CPU-side word/mask types and
// the bridge FSM state encoding.
package mem_bridge_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam int MEMBR_TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    MEMBR_IDLE,
    MEMBR_REQ,
    MEMBR_WAIT,
    MEMBR_RESP
  } lc3b_membr_state;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for the bridge: counts cycles spent waiting on the bus
// and flags the last allowed cycle.
module mem_timeout_ctr
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic term
);

  // term marks the TIMEOUT-th enabled cycle, i.e. the count before increment.
  localparam logic [MEMBR_TIMEOUT_W-1:0] TERM_CNT = MEMBR_TIMEOUT_W'(TIMEOUT - 1);

  logic [MEMBR_TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + MEMBR_TIMEOUT_W'(1);
    end
  end

  assign term = en && (cnt == TERM_CNT);

endmodule

// File: rtl/mem_bridge.sv
// Bridge from the LC-3b level-held memory port to a req/gnt/ack bus: one bus
// transaction per CPU request, single-cycle mem_resp, watchdog on dead bus.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  lc3b_word        mem_address,
  input  lc3b_word        mem_wdata,
  input  logic            mem_read,
  input  logic            mem_write,
  input  lc3b_mem_wmask   mem_byte_enable,
  output logic            mem_resp,
  output lc3b_word        mem_rdata,
  output logic            mem_err,
  output logic            pmem_req,
  output logic            pmem_we,
  output lc3b_word        pmem_addr,
  output lc3b_word        pmem_wdata,
  output lc3b_mem_wmask   pmem_wmask,
  input  logic            pmem_gnt,
  input  logic            pmem_ack,
  input  lc3b_word        pmem_rdata,
  output lc3b_membr_state state
);

  // Handshake: the CPU holds mem_read/mem_write until mem_resp pulses for one
  // cycle; on the bus pmem_req stays high until pmem_gnt, then pmem_ack
  // (possibly in the grant cycle) completes the transfer.

  lc3b_membr_state state_q, state_d;
  logic            start;
  logic            done_ack;
  logic            done_timeout;
  logic            term;
  logic            err_q;
  lc3b_word        rdata_q;
  lc3b_word        addr_q;
  lc3b_word        wdata_q;
  lc3b_mem_wmask   wmask_q;
  logic            we_q;

  assign start = (state_q == MEMBR_IDLE) && (mem_read || mem_write);

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == MEMBR_IDLE),
    .en   ((state_q == MEMBR_REQ) || (state_q == MEMBR_WAIT)),
    .term (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEMBR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack always takes priority over the watchdog in the same cycle.
  always_comb begin
    state_d      = state_q;
    done_ack     = 1'b0;
    done_timeout = 1'b0;
    case (state_q)
      MEMBR_IDLE: begin
        if (mem_read || mem_write) state_d = MEMBR_REQ;
      end
      MEMBR_REQ: begin
        if (pmem_gnt && pmem_ack) begin
          state_d  = MEMBR_RESP;
          done_ack = 1'b1;
        end else if (term) begin
          state_d      = MEMBR_RESP;
          done_timeout = 1'b1;
        end else if (pmem_gnt) begin
          state_d = MEMBR_WAIT;
        end
      end
      MEMBR_WAIT: begin
        if (pmem_ack) begin
          state_d  = MEMBR_RESP;
          done_ack = 1'b1;
        end else if (term) begin
          state_d      = MEMBR_RESP;
          done_timeout = 1'b1;
        end
      end
      MEMBR_RESP: begin
        state_d = MEMBR_IDLE;
      end
      default: begin
        state_d = MEMBR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
    end else if (start) begin
      addr_q  <= {mem_address[15:1], 1'b0};
      wdata_q <= mem_wdata;
      we_q    <= mem_write;
      wmask_q <= mem_write ? mem_byte_enable : 2'b11;
    end
  end

  // Read data is held between captures; a timeout reports zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (done_ack) begin
      err_q <= 1'b0;
      if (!we_q) rdata_q <= pmem_rdata;
    end else if (done_timeout) begin
      err_q   <= 1'b1;
      rdata_q <= '0;
    end else if (state_q == MEMBR_RESP) begin
      err_q <= 1'b0;
    end
  end

  assign mem_resp   = (state_q == MEMBR_RESP);
  assign mem_err    = err_q;
  assign mem_rdata  = rdata_q;
  assign pmem_req   = (state_q == MEMBR_REQ);
  assign pmem_we    = we_q;
  assign pmem_addr  = addr_q;
  assign pmem_wdata = wdata_q;
  assign pmem_wmask = wmask_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: a driver plays CPU and bus, pushing the
// expected completion of each request; a monitor checks every mem_resp.
module tb_mem_bridge;
  import mem_bridge_pkg::*;

  localparam int TO = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [1:0]  wmask;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [15:0]     mem_address;
  logic [15:0]     mem_wdata;
  logic            mem_read;
  logic            mem_write;
  logic [1:0]      mem_byte_enable;
  logic            mem_resp;
  logic [15:0]     mem_rdata;
  logic            mem_err;
  logic            pmem_req;
  logic            pmem_we;
  logic [15:0]     pmem_addr;
  logic [15:0]     pmem_wdata;
  logic [1:0]      pmem_wmask;
  logic            pmem_gnt;
  logic            pmem_ack;
  logic [15:0]     pmem_rdata;
  lc3b_membr_state dut_state;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_gnt = 0;
  int          exp_gnt = 0;
  logic [15:0] model_rdata = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  mem_bridge #(
    .TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_byte_enable(mem_byte_enable),
    .mem_resp       (mem_resp),
    .mem_rdata      (mem_rdata),
    .mem_err        (mem_err),
    .pmem_req       (pmem_req),
    .pmem_we        (pmem_we),
    .pmem_addr      (pmem_addr),
    .pmem_wdata     (pmem_wdata),
    .pmem_wmask     (pmem_wmask),
    .pmem_gnt       (pmem_gnt),
    .pmem_ack       (pmem_ack),
    .pmem_rdata     (pmem_rdata),
    .state          (dut_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus grants actually taken (request and grant overlapping at an edge).
  always @(posedge clk) begin
    if (rst_n && pmem_req && pmem_gnt) n_gnt++;
  end

  // monitor
  always @(negedge clk) begin
    if (rst_n && mem_resp) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_resp: got mem_resp=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_cycle", cyc, mon_e.cyc);
        check("mem_err", mem_err, mon_e.err);
        check("mem_rdata", mem_rdata, mon_e.rdata);
        check("pmem_addr", pmem_addr, mon_e.addr);
        check("pmem_wdata", pmem_wdata, mon_e.wdata);
        check("pmem_we", pmem_we, mon_e.we);
        check("pmem_wmask", pmem_wmask, mon_e.wmask);
      end
    end
  end

  // Called at the negedge of an IDLE cycle. Grant arrives g cycles and ack
  // a cycles after the request is seen; the request stays held through the
  // response cycle and is dropped at the following negedge.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] be,
                        input int g, input int a, input logic [15:0] rv);
    exp_t e;
    int   last;
    last = (a <= TO) ? a : TO;
    mem_read        = rd;
    mem_write       = wr;
    mem_address     = addr;
    mem_wdata       = wd;
    mem_byte_enable = be;
    e.cyc   = 32'(cyc + last + 1);
    e.err   = (a > TO);
    e.we    = wr;
    e.addr  = {addr[15:1], 1'b0};
    e.wdata = wd;
    e.wmask = wr ? be : 2'b11;
    if (e.err) model_rdata = 16'h0000;
    else if (!wr) model_rdata = rv;
    e.rdata = model_rdata;
    if (g <= TO) exp_gnt++;
    exp_q.push_back(e);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check("req_level", {31'd0, pmem_req}, {31'd0, (k <= g)});
      pmem_gnt        = (k == g);
      pmem_ack        = (k == a);
      pmem_rdata      = (k == a) ? rv : 16'($urandom);
      mem_address     = 16'($urandom);
      mem_wdata       = 16'($urandom);
      mem_byte_enable = 2'($urandom);
    end
    @(negedge clk);
    pmem_gnt = 1'b0;
    pmem_ack = 1'b0;
    check("req_in_resp", {31'd0, pmem_req}, 32'd0);
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check("rdata_hold", mem_rdata, model_rdata);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_resp"}, mem_resp, 0);
    check({tag, "_mem_err"}, mem_err, 0);
    check({tag, "_mem_rdata"}, mem_rdata, 0);
    check({tag, "_pmem_req"}, pmem_req, 0);
    check({tag, "_pmem_we"}, pmem_we, 0);
    check({tag, "_pmem_addr"}, pmem_addr, 0);
    check({tag, "_pmem_wdata"}, pmem_wdata, 0);
    check({tag, "_pmem_wmask"}, pmem_wmask, 0);
  endtask

  initial begin
    int op;
    int g;
    int a;
    rst_n           = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    pmem_gnt        = 1'b0;
    pmem_ack        = 1'b0;
    pmem_rdata      = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_state", dut_state, MEMBR_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // read: grant 1, ack 3
    do_txn(1'b1, 1'b0, 16'h1234, 16'h0000, 2'b01, 1, 3, 16'hBEEF);
    // write, odd address, upper lane only
    do_txn(1'b0, 1'b1, 16'h3001, 16'h5A00, 2'b10, 1, 2, 16'h0000);
    // ack lands exactly on the timeout cycle
    do_txn(1'b1, 1'b0, 16'h4444, 16'h0000, 2'b00, 2, TO, 16'hCAFE);

    // async reset while waiting for ack
    mem_read    = 1'b1;
    mem_address = 16'h5555;
    @(negedge clk);
    pmem_gnt = 1'b1;
    @(negedge clk);
    pmem_gnt = 1'b0;
    exp_gnt++;
    check("state_before_reset", dut_state, MEMBR_WAIT);
    rst_n    = 1'b0;
    mem_read = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    model_rdata = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stray_resp", mem_resp, 0);
      check("stray_req", pmem_req, 0);
      pmem_ack = 1'b1;
      pmem_gnt = 1'b1;
    end
    @(negedge clk);
    pmem_ack = 1'b0;
    pmem_gnt = 1'b0;

    // no ack at all -> error response
    do_txn(1'b1, 1'b0, 16'h2222, 16'h0000, 2'b11, 1, 100, 16'h1111);
    // read and write together: write wins, minimum latency
    do_txn(1'b1, 1'b1, 16'h0101, 16'h77AA, 2'b01, 1, 1, 16'h9999);
    // grant never arrives in time
    do_txn(1'b0, 1'b1, 16'h0F0F, 16'h1357, 2'b11, TO + 2, TO + 3, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op = $urandom_range(0, 2);
      g  = $urandom_range(1, TO + 1);
      a  = g + $urandom_range(0, 3);
      do_txn(op != 1, op != 0, 16'($urandom), 16'($urandom), 2'($urandom),
             g, a, 16'($urandom));
    end

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("grant_count", n_gnt, exp_gnt);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
